ps2_key_tracker: RTL and testbench

Parametrised PS/2 scan-code decoder that sits between the PS2_Controller byte receiver and the game logic. It decodes make (press), break (release) and E0-extended sequences for a configurable table of keys, and maintains a per-key held bitmap for paddle control. Mapped press/release events are buffered in a show-ahead FIFO with a valid/ready handshake. An ASCII "last key" byte is kept for the LCD.

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_evt_fifo.sv | 74 +++++++
 rtl/ps2_key_tracker.sv | 147 ++++++++++++++
 tb/tb_ps2_key_tracker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key tracker: decoder states, prefix and control bytes, default keys.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  // Decoder state encoding
  typedef logic [1:0] ps2_state_t;
  localparam ps2_state_t ST_IDLE      = 2'd0;
  localparam ps2_state_t ST_EXT       = 2'd1;
  localparam ps2_state_t ST_BREAK     = 2'd2;
  localparam ps2_state_t ST_EXT_BREAK = 2'd3;

  // Sequence prefixes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Keyboard control/status bytes that never carry a key code
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR    = 8'hFF;
  localparam logic [7:0] PS2_OVR    = 8'h00;

  // Default paddle keys (set-2 scan codes) and their ASCII
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_I = 8'h43;
  localparam logic [7:0] SC_K = 8'h42;

  localparam logic [7:0] ASC_W     = 8'h57;
  localparam logic [7:0] ASC_S     = 8'h53;
  localparam logic [7:0] ASC_I     = 8'h49;
  localparam logic [7:0] ASC_K     = 8'h4B;
  localparam logic [7:0] ASC_SPACE = 8'h20;

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR) || (b == PS2_OVR);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead FIFO with flush and occupancy count.
// Latency: write visible at rd_dat/empty one cycle later; rd_dat is combinational from the head.
// Backpressure: write while full is dropped unless a read happens in the same cycle.
module ps2_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                       inclock,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_rdy,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign count  = cnt_q;
  assign rd_dat = mem_q[rd_ptr_q];

  // Pointer/count/storage update; flush wins over any same-cycle write or read.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_rd    = rd_rdy && !empty && !flush;
    do_wr    = wr_vld && !flush && (!full || do_rd);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge inclock) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 make/break/E0 decoder with held-key bitmap, last-key ASCII and a buffered event stream.
// Latency: one registered stage from rx_valid to key_held/last_ascii/evt_count/evt_valid.
// Backpressure: evt_valid/evt_ready; events arriving while the FIFO is full are dropped and flag overflow.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                     NUM_KEYS        = 4,
  parameter int                     FIFO_DEPTH      = 8,
  parameter logic [NUM_KEYS*9-1:0]  KEY_CODES       = {1'b0, SC_K, 1'b0, SC_I, 1'b0, SC_S, 1'b0, SC_W},
  parameter logic [NUM_KEYS*8-1:0]  KEY_ASCII       = {ASC_K, ASC_I, ASC_S, ASC_W},
  parameter bit                     SUPPRESS_REPEAT = 1'b1
) (
  input  logic                              inclock,
  input  logic                              resetn,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  input  logic                              flush,
  output logic [NUM_KEYS-1:0]               key_held,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [$clog2(NUM_KEYS):0]         evt_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   evt_count,
  output logic                              overflow,
  output logic [7:0]                        last_ascii
);

  localparam int EVT_W = 1 + $clog2(NUM_KEYS);
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  ps2_state_t          state_q, state_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [7:0]          ascii_q, ascii_d;
  logic                ovf_q, ovf_d;

  logic                code_ext, code_brk;
  logic                hit;
  logic [NUM_KEYS-1:0] hit_mask;
  logic [IDX_W-1:0]    hit_idx;
  logic [7:0]          hit_ascii;
  logic                push_vld;
  logic [EVT_W-1:0]    push_dat;
  logic                pop;
  logic                fifo_full, fifo_empty;

  assign code_ext = (state_q == ST_EXT)   || (state_q == ST_EXT_BREAK);
  assign code_brk = (state_q == ST_BREAK) || (state_q == ST_EXT_BREAK);
  assign pop      = !fifo_empty && evt_ready;

  // Key table lookup: scan high-to-low so the lowest matching entry is the one left standing
  always_comb begin
    hit       = 1'b0;
    hit_mask  = '0;
    hit_idx   = '0;
    hit_ascii = ASC_SPACE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[i*9 +: 9] == {code_ext, rx_data}) begin
        hit       = 1'b1;
        hit_mask  = NUM_KEYS'(1) << i;
        hit_idx   = IDX_W'(i);
        hit_ascii = KEY_ASCII[i*8 +: 8];
      end
    end
  end

  // Prefix FSM plus held-bitmap/ASCII/event generation for a completed code
  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    ascii_d  = ascii_q;
    push_vld = 1'b0;
    push_dat = '0;
    if (rx_valid) begin
      if (is_ctrl(rx_data)) begin
        state_d = ST_IDLE;
      end else if (rx_data == PS2_EXT) begin
        state_d = ST_EXT;
      end else if (rx_data == PS2_BRK) begin
        state_d = code_ext ? ST_EXT_BREAK : ST_BREAK;
      end else begin
        state_d = ST_IDLE;
        if (hit) begin
          push_dat            = EVT_W'(hit_idx);
          push_dat[EVT_W-1]   = !code_brk;
          if (code_brk) begin
            held_d   = held_q & ~hit_mask;
            push_vld = 1'b1;
            if (held_d == '0) begin
              ascii_d = ASC_SPACE;
            end
          end else begin
            held_d   = held_q | hit_mask;
            ascii_d  = hit_ascii;
            // Typematic repeats of a key already down are optionally swallowed
            push_vld = !(SUPPRESS_REPEAT && ((held_q & hit_mask) != '0));
          end
        end
      end
    end
  end

  // Sticky drop flag: set when an event finds the FIFO full with no room freed this cycle
  always_comb begin
    ovf_d = ovf_q;
    if (flush) begin
      ovf_d = 1'b0;
    end else if (push_vld && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge inclock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      ascii_q <= ASC_SPACE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      ascii_q <= ascii_d;
      ovf_q   <= ovf_d;
    end
  end

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .inclock (inclock),
    .resetn  (resetn),
    .flush   (flush),
    .wr_vld  (push_vld),
    .wr_dat  (push_dat),
    .rd_rdy  (evt_ready),
    .rd_dat  (evt_data),
    .count   (evt_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign key_held   = held_q;
  assign evt_valid  = !fifo_empty;
  assign overflow   = ovf_q;
  assign last_ascii = ascii_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomized + directed bench for ps2_key_tracker against a queue-based reference model.
// Latency: n/a.
// Backpressure: evt_ready driven randomly or per directed scenario.
module tb_ps2_key_tracker;

  localparam int NK    = 5;
  localparam int DEPTH = 8;
  localparam int EW    = 1 + $clog2(NK);
  localparam int CW    = $clog2(DEPTH + 1);

  logic          inclock = 1'b0;
  logic          resetn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          flush;
  logic          evt_ready;

  logic [NK-1:0] key_held;
  logic          evt_valid;
  logic [EW-1:0] evt_data;
  logic [CW-1:0] evt_count;
  logic          overflow;
  logic [7:0]    last_ascii;

  logic [3:0]    key_held1;
  logic          evt_valid1;
  logic [2:0]    evt_data1;
  logic [3:0]    evt_count1;
  logic          overflow1;
  logic [7:0]    last_ascii1;
  logic          evt_ready1 = 1'b0;

  always #5 inclock = ~inclock;

  // Five keys: W S I K plus an extended key E0 75 (ASCII 'U')
  ps2_key_tracker #(
    .NUM_KEYS        (NK),
    .FIFO_DEPTH      (DEPTH),
    .KEY_CODES       ({9'h175, 9'h042, 9'h043, 9'h01B, 9'h01D}),
    .KEY_ASCII       ({8'h55, 8'h4B, 8'h49, 8'h53, 8'h57}),
    .SUPPRESS_REPEAT (1'b1)
  ) dut (
    .inclock (inclock), .resetn (resetn), .rx_data (rx_data), .rx_valid (rx_valid),
    .flush (flush), .key_held (key_held), .evt_valid (evt_valid), .evt_ready (evt_ready),
    .evt_data (evt_data), .evt_count (evt_count), .overflow (overflow), .last_ascii (last_ascii)
  );

  // Default table, repeats not suppressed
  ps2_key_tracker #(
    .SUPPRESS_REPEAT (1'b0)
  ) dut_rep (
    .inclock (inclock), .resetn (resetn), .rx_data (rx_data), .rx_valid (rx_valid),
    .flush (flush), .key_held (key_held1), .evt_valid (evt_valid1), .evt_ready (evt_ready1),
    .evt_data (evt_data1), .evt_count (evt_count1), .overflow (overflow1), .last_ascii (last_ascii1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit armed  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  logic [8:0]    m_codes [NK] = '{9'h01D, 9'h01B, 9'h043, 9'h042, 9'h175};
  logic [7:0]    m_asc   [NK] = '{8'h57, 8'h53, 8'h49, 8'h4B, 8'h55};
  bit            m_ext, m_brk, m_ovf;
  logic [NK-1:0] m_held;
  logic [7:0]    m_ascii;
  logic [EW-1:0] m_q[$];

  task automatic model_step(input bit rst, input bit v, input logic [7:0] b, input bit fl, input bit rdy);
    bit            has_ev, found, pop, was_full;
    logic [EW-1:0] ev;
    logic [NK-1:0] mask;
    logic [7:0]    asc;
    int            id;
    if (rst) begin
      m_ext = 0; m_brk = 0; m_ovf = 0; m_held = '0; m_ascii = 8'h20; m_q.delete();
      return;
    end
    has_ev = 0; ev = '0; found = 0; mask = '0; asc = 8'h00; id = 0;
    if (v) begin
      if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF, 8'h00}) begin
        m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else begin
        for (int i = 0; i < NK; i++) begin
          if (!found && m_codes[i] == {m_ext, b}) begin
            found = 1; mask = NK'(1) << i; asc = m_asc[i]; id = i;
          end
        end
        if (found) begin
          ev = EW'(id);
          ev[EW-1] = !m_brk;
          if (m_brk) begin
            m_held = m_held & ~mask;
            has_ev = 1;
            if (m_held == '0) m_ascii = 8'h20;
          end else begin
            has_ev = ((m_held & mask) == '0);
            m_held = m_held | mask;
            m_ascii = asc;
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end
    if (fl) begin
      m_q.delete();
      m_ovf = 0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      pop = rdy && (m_q.size() > 0);
      if (pop) void'(m_q.pop_front());
      if (has_ev) begin
        if (was_full && !pop) m_ovf = 1;
        else m_q.push_back(ev);
      end
    end
  endtask

  task automatic compare_all();
    chk("held", key_held, m_held);
    chk("ascii", last_ascii, m_ascii);
    chk("count", evt_count, m_q.size());
    chk("valid", evt_valid, m_q.size() > 0);
    chk("ovf", overflow, m_ovf);
    if (m_q.size() > 0) chk("data", evt_data, m_q[0]);
  endtask

  // One clock: check outputs at the negedge, drive next inputs, advance the model, wait one cycle
  task automatic step(input bit rst, input bit v, input logic [7:0] b, input bit fl, input bit rdy);
    if (armed) compare_all();
    resetn    = !rst;
    rx_valid  = v;
    rx_data   = b;
    flush     = fl;
    evt_ready = rdy;
    model_step(rst, v, b, fl, rdy);
    @(negedge inclock);
  endtask

  task automatic send(input logic [7:0] b);
    step(0, 1, b, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 8'h00, 0, 0);
  endtask

  logic [7:0] pool [12] = '{8'h1D, 8'h1B, 8'h43, 8'h42, 8'h75, 8'hE0,
                            8'hF0, 8'hAA, 8'h1C, 8'h00, 8'hF0, 8'hE0};

  initial begin
    resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; flush = 1'b0; evt_ready = 1'b0;
    do_reset();
    armed = 1;
    do_reset();
    chk("rst_held", key_held, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_data", evt_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ascii", last_ascii, 8'h20);

    // Typematic W W W: suppressed on dut, three events on dut_rep
    repeat (3) send(8'h1D);
    chk("tm_cnt", evt_count, 1);
    chk("tm_rep_cnt", evt_count1, 3);
    chk("tm_rep_held", key_held1, 4'b0001);
    chk("tm_rep_ascii", last_ascii1, 8'h57);
    chk("tm_rep_data", evt_data1, 3'b100);
    chk("tm_rep_vld", evt_valid1, 1);
    chk("tm_rep_ovf", overflow1, 0);

    // Make then break of W
    do_reset();
    send(8'h1D);
    chk("mb_held1", key_held, 5'b00001);
    chk("mb_ascii1", last_ascii, 8'h57);
    chk("mb_data1", evt_data, 4'h8);
    send(8'hF0); send(8'h1D);
    chk("mb_held0", key_held, 0);
    chk("mb_ascii0", last_ascii, 8'h20);
    chk("mb_cnt", evt_count, 2);
    step(0, 0, 8'h00, 0, 1);
    chk("mb_pop_data", evt_data, 4'h0);
    step(0, 0, 8'h00, 0, 1);
    chk("mb_empty", evt_valid, 0);

    // Extended key
    do_reset();
    send(8'hE0); send(8'h75);
    chk("ext_held", key_held, 5'b10000);
    chk("ext_ascii", last_ascii, 8'h55);
    chk("ext_data", evt_data, 4'hC);
    send(8'h75);
    chk("ext_plain_cnt", evt_count, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_brk_held", key_held, 0);
    chk("ext_brk_cnt", evt_count, 2);

    // Overflow: ten events into eight slots
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(8'h1D); send(8'hF0); send(8'h1D);
    end
    chk("of_cnt", evt_count, 8);
    chk("of_ovf", overflow, 1);
    chk("of_head", evt_data, 4'h8);
    step(0, 1, 8'h1D, 0, 1);
    chk("of_pushpop_cnt", evt_count, 8);
    for (int k = 1; k <= 8; k++) begin
      chk("of_order", evt_data, (k % 2 == 1) ? 4'h0 : 4'h8);
      step(0, 0, 8'h00, 0, 1);
    end
    chk("of_drained", evt_count, 0);
    chk("of_sticky", overflow, 1);
    step(0, 1, 8'h1B, 1, 0);
    chk("fl_cnt", evt_count, 0);
    chk("fl_ovf", overflow, 0);
    chk("fl_held", key_held, 5'b00011);

    // Unmapped / control / unmapped break
    do_reset();
    send(8'h1C); send(8'hAA); send(8'hF0); send(8'h15);
    send(8'hE0); send(8'hAA); send(8'h75);
    chk("ctl_cnt", evt_count, 0);
    chk("ctl_held", key_held, 0);
    send(8'h1B);
    chk("ctl_s_held", key_held, 5'b00010);
    chk("ctl_s_data", evt_data, 4'h9);

    // Reset discards an E0 prefix
    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h43);
    chk("rp_held", key_held, 5'b00100);
    chk("rp_data", evt_data, 4'hA);
    chk("rp_ascii", last_ascii, 8'h49);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] b;
      b = ($urandom_range(7) == 0) ? 8'($urandom) : pool[$urandom_range(11)];
      step($urandom_range(399) == 0, $urandom_range(4) != 0, b,
           $urandom_range(63) == 0, $urandom_range(1) == 1);
    end
    step(0, 0, 8'h00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
